// File: rtl/led_palette_arbiter_if.sv
// Request bus into the LED palette arbiter: one valid/ready handshake lane per requester.
interface led_palette_arbiter_if #(
    parameter int parm_requester_count = 2,
    parameter int parm_index_bits      = 2
);
    logic [parm_requester_count-1:0]                 req_valid;
    logic [parm_requester_count-1:0]                 req_ready;
    logic [parm_requester_count-1:0]                 req_is_basic;
    logic [parm_requester_count*parm_index_bits-1:0] req_index;
    logic [parm_requester_count*24-1:0]              req_rgb;
    logic [parm_requester_count-1:0]                 req_fade;

    modport master (
        output req_valid, req_is_basic, req_index, req_rgb, req_fade,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_is_basic, req_index, req_rgb, req_fade,
        output req_ready
    );
endinterface

// File: rtl/led_palette_arbiter.sv
// Round-robin arbiter owning the LED PWM palette; applies requests immediately or as
// a linear one-LSB-per-tick fade toward the requested target.
module led_palette_arbiter #(
    parameter int parm_color_led_count        = 4,
    parameter int parm_basic_led_count        = 4,
    parameter int parm_requester_count        = 2,
    parameter int parm_index_bits             = 2,
    parameter int parm_FCLK                   = 40_000_000,
    parameter int parm_fade_step_microseconds = 1000
) (
    input  logic                              i_clk,
    input  logic                              i_arstn,
    led_palette_arbiter_if.slave              req,
    output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
    output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
    output logic                              o_fade_busy,
    output logic                              o_err_pulse
);
    localparam int C      = parm_color_led_count;
    localparam int B      = parm_basic_led_count;
    localparam int R      = parm_requester_count;
    localparam int IW     = parm_index_bits;
    localparam int IXW    = IW + 1;
    localparam int NCH    = 3 * C + B;
    localparam int PW     = (R > 1) ? $clog2(R) : 1;
    localparam int C_TICK = (parm_FCLK / 1_000_000) * parm_fade_step_microseconds;
    localparam int TW     = (C_TICK > 1) ? $clog2(C_TICK) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] sel;
    logic [PW-1:0] sel_hi;
    logic [PW-1:0] sel_lo;
    logic          hit_hi;
    logic          hit_lo;
    logic          xfer;

    logic          sel_basic;
    logic          sel_fade;
    logic [IW-1:0] sel_index;
    logic [23:0]   sel_rgb;
    logic          in_range;
    logic          wr_ok;

    logic [TW-1:0] tick_q;
    logic          strobe;

    logic [7:0]    cur_q   [NCH];
    logic [7:0]    tgt_q   [NCH];
    logic [7:0]    cur_nxt [NCH];
    logic [7:0]    tgt_nxt [NCH];
    logic          wr_hit;
    logic [7:0]    wr_val;
    logic          busy_nxt;

    // Requesters at or above the pointer win over those below it (wrap search);
    // within each group the lowest index wins.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int j = R - 1; j >= 0; j--) begin
            if (req.req_valid[j]) begin
                if (j >= int'(ptr_q)) begin
                    hit_hi = 1'b1;
                    sel_hi = PW'(j);
                end else begin
                    hit_lo = 1'b1;
                    sel_lo = PW'(j);
                end
            end
        end
        xfer          = hit_hi | hit_lo;
        sel           = hit_hi ? sel_hi : sel_lo;
        ptr_nxt       = (sel == PW'(R - 1)) ? '0 : sel + 1'b1;
        req.req_ready = '0;
        if (xfer) begin
            req.req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        sel_basic = 1'b0;
        sel_fade  = 1'b0;
        sel_index = '0;
        sel_rgb   = '0;
        for (int j = 0; j < R; j++) begin
            if (sel == PW'(j)) begin
                sel_basic = req.req_is_basic[j];
                sel_fade  = req.req_fade[j];
                sel_index = req.req_index[j*IW +: IW];
                sel_rgb   = req.req_rgb[j*24 +: 24];
            end
        end
        in_range = sel_basic ? ({1'b0, sel_index} < IXW'(B))
                             : ({1'b0, sel_index} < IXW'(C));
        wr_ok    = xfer && in_range;
    end

    assign strobe = (tick_q == '0);

    // Channel map: red 0..C-1, green C..2C-1, blue 2C..3C-1, basic 3C..3C+B-1.
    // The fade step is taken toward the pre-edge target, then a write overrides.
    always_comb begin
        wr_hit   = 1'b0;
        wr_val   = 8'h00;
        busy_nxt = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            cur_nxt[n] = cur_q[n];
            tgt_nxt[n] = tgt_q[n];
            if (strobe) begin
                if (cur_q[n] < tgt_q[n]) begin
                    cur_nxt[n] = cur_q[n] + 8'd1;
                end else if (cur_q[n] > tgt_q[n]) begin
                    cur_nxt[n] = cur_q[n] - 8'd1;
                end
            end

            wr_hit = 1'b0;
            wr_val = 8'h00;
            if (wr_ok) begin
                if (sel_basic) begin
                    if (n == 3 * C + int'(sel_index)) begin
                        wr_hit = 1'b1;
                        wr_val = sel_rgb[7:0];
                    end
                end else if (n == int'(sel_index)) begin
                    wr_hit = 1'b1;
                    wr_val = sel_rgb[23:16];
                end else if (n == C + int'(sel_index)) begin
                    wr_hit = 1'b1;
                    wr_val = sel_rgb[15:8];
                end else if (n == 2 * C + int'(sel_index)) begin
                    wr_hit = 1'b1;
                    wr_val = sel_rgb[7:0];
                end
            end
            if (wr_hit) begin
                tgt_nxt[n] = wr_val;
                if (!sel_fade) begin
                    cur_nxt[n] = wr_val;
                end
            end

            if (cur_nxt[n] != tgt_nxt[n]) begin
                busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            ptr_q       <= '0;
            tick_q      <= TW'(C_TICK - 1);
            o_fade_busy <= 1'b0;
            o_err_pulse <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                cur_q[n] <= 8'h00;
                tgt_q[n] <= 8'h00;
            end
        end else begin
            if (xfer) begin
                ptr_q <= ptr_nxt;
            end
            tick_q      <= strobe ? TW'(C_TICK - 1) : tick_q - 1'b1;
            o_fade_busy <= busy_nxt;
            o_err_pulse <= xfer && !in_range;
            for (int n = 0; n < NCH; n++) begin
                cur_q[n] <= cur_nxt[n];
                tgt_q[n] <= tgt_nxt[n];
            end
        end
    end

    for (genvar n = 0; n < C; n++) begin : g_color
        assign o_color_led_red_value[8*n +: 8]   = cur_q[n];
        assign o_color_led_green_value[8*n +: 8] = cur_q[C + n];
        assign o_color_led_blue_value[8*n +: 8]  = cur_q[2*C + n];
    end

    for (genvar m = 0; m < B; m++) begin : g_basic
        assign o_basic_led_lumin_value[8*m +: 8] = cur_q[3*C + m];
    end
endmodule

// File: tb/tb_led_palette_arbiter.sv
// Self-checking bench for led_palette_arbiter: directed scenarios plus random traffic
// checked against a per-LED palette model.
module tb_led_palette_arbiter;
    localparam int C       = 3;
    localparam int B       = 4;
    localparam int R       = 2;
    localparam int IW      = 2;
    localparam int FCLK    = 1_000_000;
    localparam int STEP_US = 4;
    localparam int TICK    = (FCLK / 1_000_000) * STEP_US;
    localparam int OW      = 8 * (3 * C + B) + 2;

    logic           clk   = 1'b0;
    logic           arstn = 1'b0;
    logic [8*C-1:0] red;
    logic [8*C-1:0] green;
    logic [8*C-1:0] blue;
    logic [8*B-1:0] lum;
    logic           busy;
    logic           err;

    int vectors     = 0;
    int miscompares = 0;

    // model: plane 0..2 = red/green/blue of color LEDs, plane 3 = basic luminance
    int m_cur [4][4];
    int m_tgt [4][4];
    int m_ptr;
    int m_edges;
    bit m_busy;
    bit m_err;

    led_palette_arbiter_if #(.parm_requester_count(R), .parm_index_bits(IW)) bus ();

    led_palette_arbiter #(
        .parm_color_led_count       (C),
        .parm_basic_led_count       (B),
        .parm_requester_count       (R),
        .parm_index_bits            (IW),
        .parm_FCLK                  (FCLK),
        .parm_fade_step_microseconds(STEP_US)
    ) dut (
        .i_clk                  (clk),
        .i_arstn                (arstn),
        .req                    (bus),
        .o_color_led_red_value  (red),
        .o_color_led_green_value(green),
        .o_color_led_blue_value (blue),
        .o_basic_led_lumin_value(lum),
        .o_fade_busy            (busy),
        .o_err_pulse            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [R-1:0] model_grant();
        logic [R-1:0] g;
        g = '0;
        for (int i = 0; i < R; i++) begin
            int k;
            k = (m_ptr + i) % R;
            if (g == '0 && bus.req_valid[k]) g[k] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [OW-1:0] model_outs();
        logic [8*C-1:0] r;
        logic [8*C-1:0] g;
        logic [8*C-1:0] b;
        logic [8*B-1:0] l;
        for (int n = 0; n < C; n++) begin
            r[8*n +: 8] = 8'(m_cur[0][n]);
            g[8*n +: 8] = 8'(m_cur[1][n]);
            b[8*n +: 8] = 8'(m_cur[2][n]);
        end
        for (int n = 0; n < B; n++) l[8*n +: 8] = 8'(m_cur[3][n]);
        return {r, g, b, l, m_busy, m_err};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 4; n++) begin
                m_cur[p][n] = 0;
                m_tgt[p][n] = 0;
            end
        end
        m_ptr   = 0;
        m_edges = 0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic drive(input int k, input bit v, input bit basic, input int idx,
                         input logic [23:0] rgb, input bit fade);
        bus.req_valid[k]            = v;
        bus.req_is_basic[k]         = basic;
        bus.req_index[k*IW +: IW]   = IW'(idx);
        bus.req_rgb[k*24 +: 24]     = rgb;
        bus.req_fade[k]             = fade;
    endtask

    task automatic clear_inputs();
        bus.req_valid    = '0;
        bus.req_is_basic = '0;
        bus.req_index    = '0;
        bus.req_rgb      = '0;
        bus.req_fade     = '0;
    endtask

    // Advance one clock edge on both the DUT and the model; returns at edge + 1.
    task automatic cycle();
        logic [R-1:0] g;
        bit           strobe;
        bit           basic;
        bit           fade;
        int           idx;
        logic [23:0]  rgb;
        g      = model_grant();
        strobe = (m_edges % TICK) == TICK - 1;
        @(posedge clk);
        if (strobe) begin
            for (int p = 0; p < 4; p++) begin
                for (int n = 0; n < 4; n++) begin
                    if (m_cur[p][n] < m_tgt[p][n]) m_cur[p][n]++;
                    else if (m_cur[p][n] > m_tgt[p][n]) m_cur[p][n]--;
                end
            end
        end
        m_err = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (g[k]) begin
                m_ptr = (k + 1) % R;
                basic = bus.req_is_basic[k];
                fade  = bus.req_fade[k];
                idx   = int'(bus.req_index[k*IW +: IW]);
                rgb   = bus.req_rgb[k*24 +: 24];
                if (basic) begin
                    if (idx < B) begin
                        m_tgt[3][idx] = int'(rgb[7:0]);
                        if (!fade) m_cur[3][idx] = int'(rgb[7:0]);
                    end else m_err = 1'b1;
                end else if (idx < C) begin
                    for (int p = 0; p < 3; p++) begin
                        m_tgt[p][idx] = int'(rgb[23-8*p -: 8]);
                        if (!fade) m_cur[p][idx] = int'(rgb[23-8*p -: 8]);
                    end
                end else m_err = 1'b1;
            end
        end
        m_edges++;
        m_busy = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 4; n++) begin
                if (m_cur[p][n] != m_tgt[p][n]) m_busy = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        arstn = 1'b0;
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        arstn = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < R; k++) begin
                drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 24'($urandom), 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
            vectors++;
            if ({red, green, blue, lum, busy, err} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h required 0", {red, green, blue, lum, busy, err});
            end
        end
        drive(0, 1'b0, 1'b0, 0, 24'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 1, 24'h010203, 1'b0);
        arstn = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== model_grant()) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b required %b", bus.req_ready, model_grant());
        end
        cycle();
        clear_inputs();
        vectors++;
        if ({red, green, blue, lum, busy, err} !== model_outs()) begin
            miscompares++;
            $display("FAIL reset_first_write: got %h required %h", {red, green, blue, lum, busy, err}, model_outs());
        end
    endtask

    task automatic test_immediate();
        do_reset();
        drive(0, 1'b1, 1'b0, 2, 24'h1080FF, 1'b0);
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL imm_ready: got %b required 01", bus.req_ready);
        end
        cycle();
        clear_inputs();
        vectors++;
        if ({red[23:16], green[23:16], blue[23:16]} !== 24'h1080FF) begin
            miscompares++;
            $display("FAIL imm_value: got %h required 1080ff", {red[23:16], green[23:16], blue[23:16]});
        end
        vectors++;
        if ({red[15:0], green[15:0], blue[15:0], lum, busy} !== '0) begin
            miscompares++;
            $display("FAIL imm_others: got %h required 0", {red[15:0], green[15:0], blue[15:0], lum, busy});
        end
    endtask

    task automatic test_fade();
        int        changes[$];
        logic [7:0] prev;
        do_reset();
        drive(0, 1'b1, 1'b1, 1, 24'h000003, 1'b1);
        cycle();
        clear_inputs();
        vectors++;
        if (busy !== 1'b1 || lum[15:8] !== 8'h00) begin
            miscompares++;
            $display("FAIL fade_start: got busy=%b lum=%h required busy=1 lum=00", busy, lum[15:8]);
        end
        prev = lum[15:8];
        for (int i = 0; i < 14; i++) begin
            cycle();
            vectors++;
            if ({red, green, blue, lum, busy, err} !== model_outs()) begin
                miscompares++;
                $display("FAIL fade_step%0d: got %h required %h", i, {red, green, blue, lum, busy, err}, model_outs());
            end
            if (lum[15:8] !== prev) changes.push_back(i);
            prev = lum[15:8];
        end
        vectors++;
        if (changes.size() != 3 || changes[1] - changes[0] != TICK || changes[2] - changes[1] != TICK) begin
            miscompares++;
            $display("FAIL fade_spacing: got %0d steps required 3 steps %0d cycles apart", changes.size(), TICK);
        end
        vectors++;
        if (lum[15:8] !== 8'h03 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fade_end: got lum=%h busy=%b required lum=03 busy=0", lum[15:8], busy);
        end
    endtask

    task automatic test_round_robin();
        logic [R-1:0] want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, int'($urandom_range(0, C - 1)), 24'($urandom), 1'b1);
            drive(1, 1'b1, 1'b0, int'($urandom_range(0, C - 1)), 24'($urandom), 1'b1);
            #1;
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (bus.req_ready !== want || bus.req_ready !== model_grant()) begin
                miscompares++;
                $display("FAIL rr_both%0d: got %b required %b", i, bus.req_ready, want);
            end
            cycle();
        end
        drive(0, 1'b0, 1'b0, 0, 24'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, int'($urandom_range(0, B - 1)), 24'($urandom), 1'b0);
            #1;
            vectors++;
            if (bus.req_ready !== 2'b10) begin
                miscompares++;
                $display("FAIL rr_single%0d: got %b required 10", i, bus.req_ready);
            end
            cycle();
        end
        clear_inputs();
        vectors++;
        if ({red, green, blue, lum, busy, err} !== model_outs()) begin
            miscompares++;
            $display("FAIL rr_palette: got %h required %h", {red, green, blue, lum, busy, err}, model_outs());
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        drive(0, 1'b1, 1'b0, 1, 24'hAABBCC, 1'b0);
        cycle();
        drive(0, 1'b1, 1'b0, 3, 24'h123456, 1'b0);
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL oor_ready: got %b required 01", bus.req_ready);
        end
        cycle();
        clear_inputs();
        vectors++;
        if (err !== 1'b1 || red !== 24'h00AA00 || green !== 24'h00BB00 || blue !== 24'h00CC00) begin
            miscompares++;
            $display("FAIL oor_pulse: got err=%b r=%h g=%h b=%h required err=1 r=00aa00 g=00bb00 b=00cc00",
                     err, red, green, blue);
        end
        cycle();
        vectors++;
        if (err !== 1'b0 || {red, green, blue, lum, busy, err} !== model_outs()) begin
            miscompares++;
            $display("FAIL oor_pulse_end: got %h required %h", {red, green, blue, lum, busy, err}, model_outs());
        end
    endtask

    task automatic test_collision();
        int guard;
        do_reset();
        drive(0, 1'b1, 1'b0, 0, 24'h404040, 1'b0);
        cycle();
        drive(1, 1'b1, 1'b0, 0, 24'h808080, 1'b1);
        drive(0, 1'b0, 1'b0, 0, 24'h0, 1'b0);
        cycle();
        clear_inputs();
        guard = 0;
        while (!((m_edges % TICK) == TICK - 1 && m_cur[0][0] > 'h40) && guard < 20) begin
            cycle();
            guard++;
        end
        vectors++;
        if (guard >= 20 || {red, green, blue, lum, busy, err} !== model_outs() || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_setup: got %h required %h", {red, green, blue, lum, busy, err}, model_outs());
        end
        drive(0, 1'b1, 1'b0, 0, 24'h202020, 1'b0);
        cycle();
        clear_inputs();
        vectors++;
        if ({red[7:0], green[7:0], blue[7:0]} !== 24'h202020 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_immediate: got rgb=%h busy=%b required rgb=202020 busy=0",
                     {red[7:0], green[7:0], blue[7:0]}, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1'b1, 1'b0, 2, 24'hFFFFFF, 1'b1);
        cycle();
        clear_inputs();
        for (int i = 0; i < 6; i++) cycle();
        vectors++;
        if ({red, green, blue, lum, busy, err} !== model_outs() || red[23:16] === 8'h00) begin
            miscompares++;
            $display("FAIL areset_pre: got %h required %h", {red, green, blue, lum, busy, err}, model_outs());
        end
        #2;
        arstn = 1'b0;
        #1;
        vectors++;
        if ({red, green, blue, lum, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL areset_async: got %h required 0", {red, green, blue, lum, busy, err});
        end
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < R; k++) begin
                drive(k, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 24'($urandom), 1'($urandom_range(0, 1)));
            end
            #1;
            vectors++;
            if (bus.req_ready !== model_grant()) begin
                miscompares++;
                $display("FAIL rand_ready%0d: got %b required %b", i, bus.req_ready, model_grant());
            end
            cycle();
            vectors++;
            if ({red, green, blue, lum, busy, err} !== model_outs()) begin
                miscompares++;
                $display("FAIL rand_out%0d: got %h required %h", i, {red, green, blue, lum, busy, err}, model_outs());
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_immediate();
        test_fade();
        test_round_robin();
        test_out_of_range();
        test_collision();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
